// File: rtl/sram_port0_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the SRAM port-0 initiator:
//   DEF_*          default geometry of the SRAM macro
//   ctrl_state_t   controller mode (zero-fill after reset, then normal service)
//   IDLE_*         pin levels driven while the macro is not selected
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ctrl_state_t;

  localparam logic IDLE_CSB       = 1'b1;
  localparam logic IDLE_WEB       = 1'b1;
  localparam logic IDLE_WMASK_BIT = 1'b0;

endpackage

// File: rtl/sram_port0_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_port0_ctrl_if
// Request/response stream between the core (master) and the SRAM port-0
// controller (slave).
//   req_valid/req_ready  request handshake, transfer on both high at clk edge
//   req_we               1 = write, 0 = read
//   req_wmask            byte enables for writes
//   req_addr/req_wdata   word address and write data
//   rsp_valid/rsp_ready  read-response handshake
//   rsp_rdata            read data, returned in request order
// ---------------------------------------------------------------------------
interface sram_port0_ctrl_if #(
  parameter int DATA_WIDTH = sram_ctrl_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_ctrl_pkg::DEF_ADDR_WIDTH,
  parameter int NUM_WMASKS = sram_ctrl_pkg::DEF_NUM_WMASKS
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_port0_ctrl_rsp_fifo.sv
// ---------------------------------------------------------------------------
// sram_rsp_fifo
// Synchronous FIFO holding SRAM read data until the consumer takes it.
//   clk0, resetn   clock and synchronous active-low reset (pointers/count only)
//   i_push/i_data  write an entry (dropped if full; flagged by assertion)
//   i_pop          remove the head entry (ignored when empty)
//   o_data         head entry
//   o_count        occupancy
//   o_full/o_empty status flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sram_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk0,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk0) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset: only entries behind the pointers are ever read.
  always_ff @(posedge clk0) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk0) begin
    if (resetn) assert (!(i_push && o_full));
  end

endmodule

// File: rtl/sram_port0_ctrl.sv
// ---------------------------------------------------------------------------
// sram_port0_ctrl
// Initiator for port 0 of a 1RW SRAM macro. Converts a valid/ready stream of
// byte-masked reads/writes into the macro's active-low pin protocol, returns
// read data through a response FIFO, and optionally zero-fills the array
// after reset before accepting requests.
//   clk0, resetn        clock (shared with the macro) and sync active-low reset
//   bus                 request/response stream (sram_port0_ctrl_if.slave)
//   init_done           high once the post-reset clear has finished
//   csb0/web0/wmask0/addr0/din0   registered macro pins
//   dout0               macro read data
// Read latency is two cycles from acceptance: pins at E0, macro capture at
// E1, dout0 captured into the FIFO at E2.
// ---------------------------------------------------------------------------
module sram_port0_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int NUM_WMASKS     = DEF_NUM_WMASKS,
  parameter int RSP_DEPTH      = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk0,
  input  logic                  resetn,
  sram_port0_ctrl_if.slave      bus,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  ctrl_state_t           r_state;
  ctrl_state_t           w_state_nxt;
  logic [ADDR_WIDTH:0]   r_clr_cnt;
  logic [ADDR_WIDTH:0]   w_clr_cnt_nxt;
  logic                  r_init_done;

  logic                  r_csb;
  logic                  r_web;
  logic [NUM_WMASKS-1:0] r_wmask;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  w_csb_nxt;
  logic                  w_web_nxt;
  logic [NUM_WMASKS-1:0] w_wmask_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] w_din_nxt;

  logic                  r_rd_vld_p0;
  logic                  r_rd_vld_p1;
  logic [CW-1:0]         r_credits;

  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_rd_accept;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_fifo_head;
  logic [CW-1:0]         w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  // Credits cover FIFO entries plus reads still in the tag pipeline, so a
  // read is only taken when its response is guaranteed a FIFO slot.
  assign w_req_ready = r_init_done & (r_state == ST_RUN) &
                       (bus.req_we | (r_credits < CW'(RSP_DEPTH)));
  assign w_accept    = bus.req_valid & w_req_ready;
  assign w_rd_accept = w_accept & ~bus.req_we;
  assign w_pop       = ~w_fifo_empty & bus.rsp_ready;

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = ~w_fifo_empty;
  assign bus.rsp_rdata = w_fifo_empty ? '0 : w_fifo_head;

  assign init_done = r_init_done;
  assign csb0      = r_csb;
  assign web0      = r_web;
  assign wmask0    = r_wmask;
  assign addr0     = r_addr;
  assign din0      = r_din;

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_csb_nxt     = IDLE_CSB;
    w_web_nxt     = IDLE_WEB;
    w_wmask_nxt   = {NUM_WMASKS{IDLE_WMASK_BIT}};
    w_addr_nxt    = r_addr;
    w_din_nxt     = r_din;
    case (r_state)
      ST_CLEAR: begin
        // The extra counter MSB marks that the last word has been issued.
        if (r_clr_cnt[ADDR_WIDTH]) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_csb_nxt     = 1'b0;
          w_web_nxt     = 1'b0;
          w_wmask_nxt   = '1;
          w_addr_nxt    = r_clr_cnt[ADDR_WIDTH-1:0];
          w_din_nxt     = '0;
          w_clr_cnt_nxt = r_clr_cnt + (ADDR_WIDTH+1)'(1);
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          w_csb_nxt   = 1'b0;
          w_web_nxt   = ~bus.req_we;
          w_wmask_nxt = bus.req_we ? bus.req_wmask : '0;
          w_addr_nxt  = bus.req_addr;
          w_din_nxt   = bus.req_wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (!resetn) begin
      r_state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_cnt   <= w_clr_cnt_nxt;
      r_init_done <= (w_state_nxt == ST_RUN);
    end
  end

  // Stage p0: pins registered at acceptance edge E0
  always_ff @(posedge clk0) begin
    if (!resetn) begin
      r_csb       <= IDLE_CSB;
      r_web       <= IDLE_WEB;
      r_wmask     <= {NUM_WMASKS{IDLE_WMASK_BIT}};
      r_addr      <= '0;
      r_din       <= '0;
      r_rd_vld_p0 <= 1'b0;
      r_rd_vld_p1 <= 1'b0;
      r_credits   <= '0;
    end else begin
      r_csb       <= w_csb_nxt;
      r_web       <= w_web_nxt;
      r_wmask     <= w_wmask_nxt;
      r_addr      <= w_addr_nxt;
      r_din       <= w_din_nxt;
      r_rd_vld_p0 <= w_rd_accept;
      // Stage p1: macro captured pins at E1; dout0 settles after its falling edge
      r_rd_vld_p1 <= r_rd_vld_p0;
      r_credits   <= r_credits + CW'(w_rd_accept) - CW'(w_pop);
    end
  end

  // Stage p2: dout0 pushed into the response FIFO at E2
  sram_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk0    (clk0),
    .resetn  (resetn),
    .i_push  (r_rd_vld_p1),
    .i_data  (dout0),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk0) begin
    if (resetn) begin
      assert (w_fifo_count <= r_credits);
      assert (!(w_fifo_full && r_rd_vld_p1));
    end
  end

endmodule
